seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller that shares one hex-to-seven-segment decoder across `DIGITS` common-anode digits. It sits between value producers (counters, status registers) and the board's segment/anode pins. It latches a new display value through a load handshake and commits it only at frame boundaries, so a frame never mixes old and new digits. Each digit slot has a blanking interval to suppress ghosting.

## Interface
- `DIGITS`, 4: number of multiplexed digits, 1–8.
- `SCAN_DIV`, 50000: clocks per digit slot; must be ≥ `BLANK_CYC`+1.
- `BLANK_CYC`, 500: clocks at the start of each slot with all anodes off; must be ≥ 1.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  single-cycle request to capture `value`.
- `value`  in  4*DIGITS  nibble i = hex digit i; digit 0 is least significant.
- `digit_en`  in  DIGITS  per-digit enable; 0 keeps that anode off for its slot.
- `pending`  out  1  high while a captured value waits for commit.
- `frame_done`  out  1  one-cycle pulse on the last cycle of each frame.
- `dout`  out  7  segments {g,f,e,d,c,b,a}, active low.
- `an`  out  DIGITS  anode selects, active low, at most one low.

## Operation
- Registers: `shadow` (4*DIGITS), `active` (4*DIGITS), slot counter `cnt` (0..SCAN_DIV-1), digit index `idx` (0..DIGITS-1), state ∈ {BLANK, SHOW}.
- Reset: `active`=0, `shadow`=0, `pending`=0, `cnt`=0, `idx`=0, state=BLANK, `dout`=7'b1111111, `an`=all ones, `frame_done`=0.
- FSM per slot: BLANK while `cnt` < `BLANK_CYC`. BLANK→SHOW when `cnt` reaches `BLANK_CYC`. SHOW→BLANK when `cnt`=`SCAN_DIV`-1; on that edge `cnt`←0 and `idx`←`idx`+1, wrapping from `DIGITS`-1 to 0.
- BLANK: `an`=all ones, `dout`=7'b1111111.
- SHOW: `an[idx]`=0 if `digit_en[idx]`, else all ones. `dout`=decode(`active` nibble `idx`), or all ones if the digit is disabled.
- Slot time is consumed even for disabled digits, so the refresh rate is constant.
- Decode, 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Load handshake:
  - `load`=1 sets `shadow`←`value` and `pending`←1.
  - A second load while pending overwrites `shadow`; the last value wins.
- Commit:
  - On the frame-end cycle (`idx`=DIGITS-1, `cnt`=SCAN_DIV-1), if `pending`=1, then `active`←`shadow` and `pending`←0.
  - A `load` in the frame-end cycle commits `value` directly, and `pending` stays 0.
- Reset mid-frame aborts the scan and discards `shadow` and `pending`.

## Timing
- Cycle 0 is the first edge after `reset` falls.
- Slot k covers cycles k*SCAN_DIV to k*SCAN_DIV+SCAN_DIV-1.
- Outputs are registered and change on the edge where state/`cnt` change. The first anode goes low at cycle `BLANK_CYC`.
- `frame_done` is high exactly at cycle DIGITS*SCAN_DIV-1 of each frame. The first slot of the next frame uses the committed value.
- `pending` rises one cycle after `load`.
- Worst-case load-to-display latency: DIGITS*SCAN_DIV + BLANK_CYC cycles.

## Configuration
- `SEG_LZ_BLANK_EN` defined:
  - Leading-zero suppression is compiled in.
  - Digit i (i>0) is blanked (`an` high, `dout` all ones) during SHOW if `active` nibbles i..DIGITS-1 are all zero.
  - Digit 0 is always shown.
- `SEG_LZ_BLANK_EN` undefined: all enabled digits are shown, including leading zeros.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
- Reset, then hold: cycles 0–1 show `an`=1111, `dout`=1111111. Cycles 2–7 show `an`=1110, `dout`=1000000. `frame_done` is high only at cycle 31.
- `load` with `value`=16'h1A3F at cycle 3:
  - `pending`=1 from cycle 4 until the commit at cycle 31.
  - Next frame: slot 0 shows 0001110, slot 1 shows 0110000, slot 2 shows 0001000, slot 3 shows 1111001, with `an` 1110/1101/1011/0111.
- Loads 16'h1111 at cycle 5, then 16'h2222 at cycle 9: after the commit every digit shows 0100100.
- `load` 16'h0005 exactly at cycle 31: the next frame shows 5 (0010010) on digit 0, and `pending` never rises.
- `digit_en`=4'b1011: `an` stays 1111 for all of slot 2, and slot 3 still starts at cycle 24.
- With `SEG_LZ_BLANK_EN` defined and `active`=16'h0040: digits 3 and 2 are blanked, digit 1 shows 0011001, digit 0 shows 1000000. Asserting `reset` at cycle 13 gives all-ones outputs on the next edge.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed hex display scanner: one shared decoder, per-slot blanking, frame-aligned commit.
// Optional leading-zero suppression is compiled in with `define SEG_LZ_BLANK_EN.
module seg_scan_ctrl #(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_load,
   input  logic [4*DIGITS-1:0]   i_value,
   input  logic [DIGITS-1:0]     i_digit_en,
   output logic                  o_pending,
   output logic                  o_frame_done,
   output logic [6:0]            o_dout,
   output logic [DIGITS-1:0]     o_an
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

   typedef enum logic {BLANK, SHOW} state_t;

   function automatic logic [6:0] f_decode(input logic [3:0] n);
      case (n)
         4'h0: f_decode = 7'b1000000;
         4'h1: f_decode = 7'b1111001;
         4'h2: f_decode = 7'b0100100;
         4'h3: f_decode = 7'b0110000;
         4'h4: f_decode = 7'b0011001;
         4'h5: f_decode = 7'b0010010;
         4'h6: f_decode = 7'b0000010;
         4'h7: f_decode = 7'b1111000;
         4'h8: f_decode = 7'b0000000;
         4'h9: f_decode = 7'b0010000;
         4'hA: f_decode = 7'b0001000;
         4'hB: f_decode = 7'b0000011;
         4'hC: f_decode = 7'b1000110;
         4'hD: f_decode = 7'b0100001;
         4'hE: f_decode = 7'b0000110;
         default: f_decode = 7'b0001110;
      endcase
   endfunction

   state_t                   r_state;
   logic [CW-1:0]            r_cnt;
   logic [IW-1:0]            r_idx;
   logic [DIGITS-1:0][3:0]   r_shadow;
   logic [DIGITS-1:0][3:0]   r_active;
   logic                     r_pending;
   logic                     r_frame_done;
   logic [6:0]               r_dout;
   logic [DIGITS-1:0]        r_an;

   logic                     w_last_slot;
   logic                     w_frame_end;
   logic [CW-1:0]            w_cnt_nxt;
   logic [IW-1:0]            w_idx_nxt;
   logic [DIGITS-1:0][3:0]   w_active_nxt;
   logic                     w_show_nxt;
   logic [DIGITS-1:0]        w_lz;
   logic                     w_digit_on;

   assign w_last_slot = (r_cnt == CNT_LAST);
   assign w_frame_end = w_last_slot && (r_idx == IDX_LAST);
   assign w_cnt_nxt   = w_last_slot ? '0 : r_cnt + CW'(1);
   assign w_idx_nxt   = !w_last_slot ? r_idx :
                        (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);

   // A load on the frame-end cycle bypasses the shadow so it lands in this frame boundary.
   always_comb begin
      w_active_nxt = r_active;
      if (w_frame_end) begin
         if (i_load)         w_active_nxt = i_value;
         else if (r_pending) w_active_nxt = r_shadow;
      end
   end

   assign w_show_nxt = (r_state == SHOW) ? !w_last_slot : (w_cnt_nxt == CNT_BLANK);

`ifdef SEG_LZ_BLANK_EN
   assign w_lz[0] = 1'b0;
   for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
      assign w_lz[gi] = (w_active_nxt[DIGITS-1:gi] == '0);
   end
`else
   assign w_lz = '0;
`endif

   assign w_digit_on = w_show_nxt && i_digit_en[w_idx_nxt] && !w_lz[w_idx_nxt];

   // Outputs are registered from next-state values so they switch on the same edge as cnt/state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= BLANK;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_shadow     <= '0;
         r_active     <= '0;
         r_pending    <= 1'b0;
         r_frame_done <= 1'b0;
         r_dout       <= '1;
         r_an         <= '1;
      end else begin
         case (r_state)
            BLANK: if (w_cnt_nxt == CNT_BLANK) r_state <= SHOW;
            SHOW:  if (w_last_slot)            r_state <= BLANK;
            default:                           r_state <= BLANK;
         endcase
         r_cnt        <= w_cnt_nxt;
         r_idx        <= w_idx_nxt;
         r_active     <= w_active_nxt;
         if (i_load) r_shadow <= i_value;
         r_pending    <= w_frame_end ? 1'b0 : (r_pending | i_load);
         r_frame_done <= (w_cnt_nxt == CNT_LAST) && (w_idx_nxt == IDX_LAST);
         r_an         <= w_digit_on ? ~(DIGITS'(1) << w_idx_nxt) : '1;
         r_dout       <= w_digit_on ? f_decode(w_active_nxt[w_idx_nxt]) : '1;
      end
   end

   assign o_pending    = r_pending;
   assign o_frame_done = r_frame_done;
   assign o_dout       = r_dout;
   assign o_an         = r_an;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position model checked every cycle plus literal scenario checks.
module tb_seg_scan_ctrl;
   localparam int DIGITS = 4, SCAN_DIV = 8, BLANK_CYC = 2;
   localparam int FRAME = DIGITS * SCAN_DIV;

   logic        clk = 1'b0, reset = 1'b1, load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  digit_en = 4'hF;
   logic        pending, frame_done;
   logic [6:0]  dout;
   logic [3:0]  an;

   seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .i_clk(clk), .i_reset(reset), .i_load(load), .i_value(value), .i_digit_en(digit_en),
      .o_pending(pending), .o_frame_done(frame_done), .o_dout(dout), .o_an(an));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [6:0] SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Model: position in frame, committed/shadow values, enable seen at the previous edge.
   int          cyc = 0, t = 0;
   logic [15:0] m_active = '0, m_shadow = '0;
   logic        m_pending = 1'b0, m_ok = 1'b0;
   logic [3:0]  m_en = 4'hF;

   always @(posedge clk) begin
      if (reset) begin
         cyc = 0; t = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0; m_ok = 1'b1;
      end else begin
         if (t == FRAME - 1) begin
            if (load)           m_active = value;
            else if (m_pending) m_active = m_shadow;
            m_pending = 1'b0;
         end else if (load) begin
            m_shadow  = value;
            m_pending = 1'b1;
         end
         cyc++;
         t = (t + 1) % FRAME;
      end
      m_en = digit_en;
   end

   always @(negedge clk) begin
      int slot, pos;
      logic [15:0] upper;
      logic show, lz;
      logic [3:0] e_an;
      logic [6:0] e_dout;
      if (m_ok) begin
         slot  = t / SCAN_DIV;
         pos   = t % SCAN_DIV;
         upper = m_active >> (4 * slot);
`ifdef SEG_LZ_BLANK_EN
         lz = (slot > 0) && (upper == 16'h0);
`else
         lz = 1'b0;
`endif
         show   = (pos >= BLANK_CYC) && m_en[slot] && !lz;
         e_an   = show ? ~(4'b0001 << slot) : 4'hF;
         e_dout = show ? SEG[upper[3:0]] : 7'h7F;
         chk("an", {28'h0, an}, {28'h0, e_an});
         chk("dout", {25'h0, dout}, {25'h0, e_dout});
         chk("frame_done", {31'h0, frame_done}, {31'h0, (t == FRAME - 1)});
         chk("pending", {31'h0, pending}, {31'h0, m_pending});
      end
   end

   task automatic do_reset(input logic [3:0] en);
      @(negedge clk);
      reset = 1'b1; load = 1'b0; digit_en = en;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic to_cyc(input int n);
      int guard = 0;
      while (cyc != n && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != n) begin
         errors++;
         $display("FAIL to_cyc timeout actual=%0d expected=%0d", cyc, n);
      end
   endtask

   task automatic pulse_load(input logic [15:0] v);
      load = 1'b1; value = v;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and hold
      do_reset(4'hF);
      chk("rst_an0", {28'h0, an}, 32'hF);
      chk("rst_dout0", {25'h0, dout}, 32'h7F);
      to_cyc(1);  chk("c1_an", {28'h0, an}, 32'hF);
      to_cyc(2);  chk("c2_an", {28'h0, an}, 32'b1110);
                  chk("c2_dout", {25'h0, dout}, 32'b1000000);
      to_cyc(7);  chk("c7_an", {28'h0, an}, 32'b1110);
      to_cyc(30); chk("c30_fd", {31'h0, frame_done}, 32'h0);
      to_cyc(31); chk("c31_fd", {31'h0, frame_done}, 32'h1);
      to_cyc(32); chk("c32_fd", {31'h0, frame_done}, 32'h0);

      // Single load, committed at the frame boundary
      do_reset(4'hF);
      to_cyc(3);  pulse_load(16'h1A3F);
      chk("pend_c4", {31'h0, pending}, 32'h1);
      to_cyc(31); chk("pend_c31", {31'h0, pending}, 32'h1);
      to_cyc(32); chk("pend_c32", {31'h0, pending}, 32'h0);
      to_cyc(34); chk("s0_dout", {25'h0, dout}, 32'b0001110); chk("s0_an", {28'h0, an}, 32'b1110);
      to_cyc(42); chk("s1_dout", {25'h0, dout}, 32'b0110000); chk("s1_an", {28'h0, an}, 32'b1101);
      to_cyc(50); chk("s2_dout", {25'h0, dout}, 32'b0001000); chk("s2_an", {28'h0, an}, 32'b1011);
      to_cyc(58); chk("s3_dout", {25'h0, dout}, 32'b1111001); chk("s3_an", {28'h0, an}, 32'b0111);

      // Last load wins
      do_reset(4'hF);
      to_cyc(5);  pulse_load(16'h1111);
      to_cyc(9);  pulse_load(16'h2222);
      to_cyc(34); chk("lw_d0", {25'h0, dout}, 32'b0100100);
      to_cyc(58); chk("lw_d3", {25'h0, dout}, 32'b0100100);

      // Load on the frame-end cycle commits directly
      do_reset(4'hF);
      to_cyc(31); pulse_load(16'h0005);
      chk("fe_pend", {31'h0, pending}, 32'h0);
      to_cyc(34); chk("fe_d0", {25'h0, dout}, 32'b0010010);

      // Disabled digit keeps its slot time
      do_reset(4'b1011);
      to_cyc(16); chk("dis_c16", {28'h0, an}, 32'hF);
      to_cyc(20); chk("dis_c20", {28'h0, an}, 32'hF);
      to_cyc(25); chk("dis_c25", {28'h0, an}, 32'hF);
      to_cyc(26); chk("dis_c26", {28'h0, an}, 32'b0111);

      // Leading-zero handling with active = 0x0040
      do_reset(4'hF);
      to_cyc(31); pulse_load(16'h0040);
      to_cyc(34); chk("lz_d0", {25'h0, dout}, 32'b1000000); chk("lz_a0", {28'h0, an}, 32'b1110);
      to_cyc(42); chk("lz_d1", {25'h0, dout}, 32'b0011001); chk("lz_a1", {28'h0, an}, 32'b1101);
`ifdef SEG_LZ_BLANK_EN
      to_cyc(50); chk("lz_d2", {25'h0, dout}, 32'h7F); chk("lz_a2", {28'h0, an}, 32'hF);
      to_cyc(58); chk("lz_a3", {28'h0, an}, 32'hF);
`else
      to_cyc(50); chk("lz_d2", {25'h0, dout}, 32'b1000000); chk("lz_a2", {28'h0, an}, 32'b1011);
      to_cyc(58); chk("lz_a3", {28'h0, an}, 32'b0111);
`endif

      // Reset mid-frame discards the pending value
      do_reset(4'hF);
      to_cyc(5);  pulse_load(16'h1234);
      to_cyc(13); chk("mid_pend", {31'h0, pending}, 32'h1);
                  chk("mid_an", {28'h0, an}, 32'b1101);
      reset = 1'b1;
      @(negedge clk);
      chk("mr_an", {28'h0, an}, 32'hF);
      chk("mr_dout", {25'h0, dout}, 32'h7F);
      chk("mr_pend", {31'h0, pending}, 32'h0);
      reset = 1'b0;
      to_cyc(34); chk("mr_d0", {25'h0, dout}, 32'b1000000);
      to_cyc(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
